// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and flag logic for an asynchronous FIFO: binary/Gray read pointer, empty, almost-empty and fill level.
// Optional sticky underflow detection is built when FIFO_UNDERFLOW_DETECT_EN is defined; otherwise runderflow is tied low.
module fifo_rptr_empty #(
  parameter int ADDRSIZE      = 7,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                runderflow
);

  localparam logic [ADDRSIZE:0] AeThresh = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rbin_q;
  logic [ADDRSIZE:0] rbin_d;
  logic [ADDRSIZE:0] rptr_q;
  logic [ADDRSIZE:0] rptr_d;
  logic [ADDRSIZE:0] rcount_q;
  logic [ADDRSIZE:0] rcount_d;
  logic [ADDRSIZE:0] wbin;
  logic              rempty_q;
  logic              rempty_d;
  logic              raempty_q;
  logic              raempty_d;
  logic              pop;

  // A request while empty is dropped, so the pointer only advances on a real pop.
  assign pop    = rinc & ~rempty_q;
  assign rbin_d = rbin_q + {{ADDRSIZE{1'b0}}, pop};
  assign rptr_d = (rbin_d >> 1) ^ rbin_d;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign rcount_d  = wbin - rbin_d;
  assign rempty_d  = (rptr_d == rq2_wptr);
  assign raempty_d = (rcount_d <= AeThresh);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rcount_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rcount_q  <= rcount_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
    end
  end

`ifdef FIFO_UNDERFLOW_DETECT_EN
  logic runderflow_q;

  // Sticky: once a read is attempted on an empty FIFO, only reset clears it.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      runderflow_q <= 1'b0;
    end else if (rinc && rempty_q) begin
      runderflow_q <= 1'b1;
    end
  end

  assign runderflow = runderflow_q;
`else
  assign runderflow = 1'b0;
`endif

  assign raddr   = rbin_q[ADDRSIZE-1:0];
  assign rptr    = rptr_q;
  assign rcount  = rcount_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed bench for fifo_rptr_empty (ADDRSIZE=3, AEMPTY_THRESH=2) with a scoreboard of expected outputs per cycle.
module tb_fifo_rptr_empty;

  localparam int ADDRSIZE      = 3;
  localparam int AEMPTY_THRESH = 2;

  typedef struct {
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [3:0] rcount;
    logic       runderflow;
  } expT;

  logic       rclk;
  logic       rrst;
  logic       rinc;
  logic [3:0] rq2_wptr;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [3:0] rcount;
  logic       runderflow;

  int  total = 0;
  int  bad   = 0;
  expT sbQ[$];

  logic [3:0] mR;
  logic       mEmpty;
  logic       mUf;
  logic [3:0] wCur;
  logic [3:0] prevRptr;
  logic [3:0] diff;
  logic       sawEmpty;

  fifo_rptr_empty #(.ADDRSIZE(ADDRSIZE), .AEMPTY_THRESH(AEMPTY_THRESH)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
    .rcount(rcount), .runderflow(runderflow)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    expT e;
    if (sbQ.size() == 0) begin
      check("sbEmpty", 32'(sbQ.size()), 32'd1);
    end else begin
      e = sbQ.pop_front();
      check("raddr",      32'(raddr),      32'(e.raddr));
      check("rptr",       32'(rptr),       32'(e.rptr));
      check("rempty",     32'(rempty),     32'(e.rempty));
      check("raempty",    32'(raempty),    32'(e.raempty));
      check("rcount",     32'(rcount),     32'(e.rcount));
      check("runderflow", 32'(runderflow), 32'(e.runderflow));
    end
  endtask

  // Drive one cycle of inputs, predict the registered outputs, then compare after the edge.
  task automatic applyStimulus(input logic rstV, input logic incV, input logic [3:0] wV);
    expT        e;
    logic [3:0] cnt;
    @(negedge rclk);
    rrst     = rstV;
    rinc     = incV;
    rq2_wptr = gray(wV);
    if (rstV) begin
      mR     = 4'd0;
      mEmpty = 1'b1;
      mUf    = 1'b0;
      cnt    = 4'd0;
    end else begin
`ifdef FIFO_UNDERFLOW_DETECT_EN
      if (incV && mEmpty) mUf = 1'b1;
`endif
      if (incV && !mEmpty) mR = mR + 4'd1;
      cnt    = wV - mR;
      mEmpty = (cnt == 4'd0);
    end
    e.raddr      = mR[2:0];
    e.rptr       = gray(mR);
    e.rempty     = mEmpty;
    e.raempty    = (cnt <= 4'd2);
    e.rcount     = cnt;
    e.runderflow = mUf;
    sbQ.push_back(e);
    @(posedge rclk);
    #1;
    checkOutput();
  endtask

  initial begin
    rrst = 1'b1; rinc = 1'b0; rq2_wptr = 4'd0;
    mR = 4'd0; mEmpty = 1'b1; mUf = 1'b0;

    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b1, 4'd0);
    check("rstRempty", 32'(rempty), 32'd1);
    check("rstRcount", 32'(rcount), 32'd0);

    // Five entries written, no reads yet.
    applyStimulus(1'b0, 1'b0, 4'd5);
    check("fill5", 32'(rcount), 32'd5);
    check("fill5Empty", 32'(rempty), 32'd0);

    for (int i = 0; i < 5; i++) begin
      check("popAddr", 32'(raddr), 32'(i));
      applyStimulus(1'b0, 1'b1, 4'd5);
    end
    check("drainEmpty", 32'(rempty), 32'd1);
    check("drainRptr", 32'(rptr), 32'h7);

    // Reads on an empty FIFO must be ignored.
    prevRptr = rptr;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd5);
      check("holdRptr", 32'(rptr), 32'(prevRptr));
    end
`ifdef FIFO_UNDERFLOW_DETECT_EN
    check("ufSet", 32'(runderflow), 32'd1);
`else
    check("ufOff", 32'(runderflow), 32'd0);
`endif

    // Full boundary: 2^ADDRSIZE entries.
    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd8);
    check("fullCount", 32'(rcount), 32'd8);

    // Full pointer wrap with writer three ahead, reads and writes in the same cycle.
    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 4'd3);
    wCur = 4'd3;
    sawEmpty = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prevRptr = rptr;
      wCur = wCur + 4'd1;
      applyStimulus(1'b0, 1'b1, wCur);
      check("wrapOneBit", 32'($countones(rptr ^ prevRptr)), 32'd1);
      if (rempty) sawEmpty = 1'b1;
    end
    check("wrapNoEmpty", 32'(sawEmpty), 32'd0);
    check("wrapCount", 32'(rcount), 32'd3);
    check("wrapRptr", 32'(rptr), 32'd0);

    // Reset mid-operation with a pending read.
    applyStimulus(1'b0, 1'b0, 4'd4);
    check("preRstCount", 32'(rcount), 32'd4);
    applyStimulus(1'b1, 1'b1, 4'd4);
    applyStimulus(1'b0, 1'b0, 4'd0);

    // Random mix of reads and writes, never overfilling.
    wCur = 4'd0;
    for (int i = 0; i < 24; i++) begin
      diff = wCur - mR;
      if ($urandom_range(0, 1) == 1 && diff < 4'd8) wCur = wCur + 4'd1;
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), wCur);
    end

    check("sbDrained", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
